// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: sequences I/D block fills as pipelined single-word
// reads and issues D-side write-through stores, one transaction at a time.
module mem_arbiter #(
    parameter int unsigned AWIDTH          = 16,
    parameter int unsigned DWIDTH          = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned MEM_LATENCY     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_miss,
    input  logic [AWIDTH-1:0]                  i_miss_addr,
    input  logic                               d_miss,
    input  logic [AWIDTH-1:0]                  d_miss_addr,
    input  logic                               d_wr_req,
    input  logic [AWIDTH-1:0]                  d_wr_addr,
    input  logic [DWIDTH-1:0]                  d_wr_data,
    output logic                               d_wr_ack,
    output logic                               mem_en,
    output logic                               mem_wr,
    output logic [AWIDTH-1:0]                  mem_addr,
    output logic [DWIDTH-1:0]                  mem_wdata,
    input  logic                               mem_data_valid,
    input  logic [DWIDTH-1:0]                  mem_rdata,
    output logic [DWIDTH-1:0]                  fill_data,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic                               i_fill_we,
    output logic                               d_fill_we,
    output logic                               i_fill_done,
    output logic                               d_fill_done,
    output logic                               busy
);

    localparam int unsigned WW   = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CW   = WW + 1;
    localparam int unsigned DRW  = $clog2(MEM_LATENCY + 1);
    localparam int unsigned BMSK = 2 * WORDS_PER_BLOCK - 1;

    typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} state_t;

    state_t            state;
    logic [CW-1:0]     issue_cnt;
    logic [CW-1:0]     rcv_cnt;
    logic [AWIDTH-1:0] base;
    logic              rr_ptr;
    logic [DRW-1:0]    drain;

    logic [AWIDTH-1:0] i_base;
    logic [AWIDTH-1:0] d_base;
    logic              filling;
    logic              accept;
    logic              last_word;

    assign i_base = i_miss_addr & ~AWIDTH'(BMSK);
    assign d_base = d_miss_addr & ~AWIDTH'(BMSK);

    // Read returns still in flight from before a reset land inside the drain window and are dropped.
    assign filling   = (state == FILL_I) || (state == FILL_D);
    assign accept    = filling && mem_data_valid && (drain == '0);
    assign last_word = (rcv_cnt == CW'(WORDS_PER_BLOCK - 1));

    assign fill_data   = mem_rdata;
    assign fill_word   = rcv_cnt[WW-1:0];
    assign i_fill_we   = accept && (state == FILL_I);
    assign d_fill_we   = accept && (state == FILL_D);
    assign i_fill_done = i_fill_we && last_word;
    assign d_fill_done = d_fill_we && last_word;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            base      <= '0;
            rr_ptr    <= 1'b0;
            drain     <= DRW'(MEM_LATENCY);
            d_wr_ack  <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (drain != '0) drain <= drain - DRW'(1);
            case (state)
                IDLE: begin
                    mem_en   <= 1'b0;
                    mem_wr   <= 1'b0;
                    d_wr_ack <= 1'b0;
                    // Stores first; competing misses alternate via rr_ptr (0 = D).
                    if (d_wr_req) begin
                        state     <= WRITE;
                        mem_en    <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= d_wr_addr;
                        mem_wdata <= d_wr_data;
                        d_wr_ack  <= 1'b1;
                    end else if (d_miss && (!i_miss || !rr_ptr)) begin
                        state     <= FILL_D;
                        base      <= d_base;
                        mem_en    <= 1'b1;
                        mem_addr  <= d_base;
                        issue_cnt <= CW'(1);
                        rcv_cnt   <= '0;
                        rr_ptr    <= 1'b1;
                    end else if (i_miss) begin
                        state     <= FILL_I;
                        base      <= i_base;
                        mem_en    <= 1'b1;
                        mem_addr  <= i_base;
                        issue_cnt <= CW'(1);
                        rcv_cnt   <= '0;
                        rr_ptr    <= 1'b0;
                    end
                end
                FILL_I, FILL_D: begin
                    if (issue_cnt < CW'(WORDS_PER_BLOCK)) begin
                        mem_en    <= 1'b1;
                        mem_addr  <= base + AWIDTH'({issue_cnt, 1'b0});
                        issue_cnt <= issue_cnt + CW'(1);
                    end else begin
                        mem_en <= 1'b0;
                    end
                    if (accept) begin
                        rcv_cnt <= rcv_cnt + CW'(1);
                        if (last_word) begin
                            state  <= IDLE;
                            mem_en <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    state     <= IDLE;
                    mem_en    <= 1'b0;
                    mem_wr    <= 1'b0;
                    mem_wdata <= '0;
                    d_wr_ack  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency pipelined memory model
// whose read data is the word address XOR 0x5A00.
module tb_mem_arbiter;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned WPB = 8;
    localparam int unsigned LAT = 4;
    localparam int unsigned FW  = $clog2(WPB);

    logic          clk = 1'b0;
    logic          rst;
    logic          i_miss, d_miss, d_wr_req;
    logic [AW-1:0] i_miss_addr, d_miss_addr, d_wr_addr;
    logic [DW-1:0] d_wr_data;
    logic          d_wr_ack, mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_data_valid;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] fill_data;
    logic [FW-1:0] fill_word;
    logic          i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy;

    int checks   = 0;
    int failures = 0;

    logic [LAT-1:0] pipe_v = '0;
    logic [AW-1:0]  pipe_a [LAT];
    logic           stray_v = 1'b0;
    logic [DW-1:0]  stray_d = '0;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .WORDS_PER_BLOCK(WPB), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory: a read sampled at a rising edge returns LAT cycles after its issue cycle.
    always @(posedge clk) begin
        pipe_v    <= {pipe_v[LAT-2:0], mem_en & ~mem_wr};
        pipe_a[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
    end

    assign mem_data_valid = pipe_v[LAT-1] | stray_v;
    assign mem_rdata      = stray_v ? stray_d : (pipe_a[LAT-1] ^ 16'h5A00);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"},   32'(busy), 32'(0));
        check({tag, " mem_en"}, 32'(mem_en), 32'(0));
        check({tag, " ack"},    32'(d_wr_ack), 32'(0));
        check({tag, " i_we"},   32'(i_fill_we), 32'(0));
        check({tag, " d_we"},   32'(d_fill_we), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
        i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at the grant cycle's midpoint; checks cycles grant+1 .. grant+WPB+LAT.
    task automatic expect_fill(input bit is_d, input logic [AW-1:0] b, input bit drop,
                               input int wr_at, input bit perturb);
        logic [AW-1:0] a;
        int            last;
        last = int'(WPB + LAT);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            check($sformatf("busy c%0d", c), 32'(busy), 32'(1));
            check($sformatf("ack c%0d", c), 32'(d_wr_ack), 32'(0));
            if (c <= int'(WPB)) begin
                a = b + AW'(2 * (c - 1));
                check($sformatf("mem_en c%0d", c), 32'(mem_en), 32'(1));
                check($sformatf("mem_wr c%0d", c), 32'(mem_wr), 32'(0));
                check($sformatf("mem_addr c%0d", c), 32'(mem_addr), 32'(a));
            end else begin
                check($sformatf("mem_en idle c%0d", c), 32'(mem_en), 32'(0));
            end
            if (c > int'(LAT)) begin
                a = b + AW'(2 * (c - int'(LAT) - 1));
                check($sformatf("we c%0d", c), 32'(is_d ? d_fill_we : i_fill_we), 32'(1));
                check($sformatf("other we c%0d", c), 32'(is_d ? i_fill_we : d_fill_we), 32'(0));
                check($sformatf("fill_word c%0d", c), 32'(fill_word), 32'(c - int'(LAT) - 1));
                check($sformatf("fill_data c%0d", c), 32'(fill_data), 32'(a ^ 16'h5A00));
            end else begin
                check($sformatf("no we c%0d", c), 32'(i_fill_we | d_fill_we), 32'(0));
            end
            check($sformatf("done c%0d", c), 32'(is_d ? d_fill_done : i_fill_done), 32'(c == last));
            check($sformatf("other done c%0d", c), 32'(is_d ? i_fill_done : d_fill_done), 32'(0));
            if (c == 1 && perturb) begin
                d_miss      = 1'b0;
                d_miss_addr = 16'h1111;
            end
            if (c == wr_at) begin
                d_wr_req  = 1'b1;
                d_wr_addr = 16'h5552;
                d_wr_data = 16'hCAFE;
            end
            if (c == last && drop) begin
                if (is_d) d_miss = 1'b0;
                else      i_miss = 1'b0;
            end
        end
    endtask

    initial begin
        do_reset();
        rst = 1'b1;
        #1;
        check_quiet("reset");
        check("reset mem_wr", 32'(mem_wr), 32'(0));
        check("reset mem_addr", 32'(mem_addr), 32'(0));
        check("reset fill_word", 32'(fill_word), 32'(0));
        check("reset dones", 32'({i_fill_done, d_fill_done}), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single I miss at 0x1236 -> block 0x1230.
        i_miss = 1'b1; i_miss_addr = 16'h1236;
        expect_fill(1'b0, 16'h1230, 1'b1, 0, 1'b0);
        @(negedge clk);
        check_quiet("t1 after");

        // Both misses pending after reset: D, I, D, then lone I.
        do_reset();
        i_miss = 1'b1; i_miss_addr = 16'h204C;
        d_miss = 1'b1; d_miss_addr = 16'h345A;
        expect_fill(1'b1, 16'h3450, 1'b0, 0, 1'b0);
        @(negedge clk); check_quiet("t2 gap1");
        expect_fill(1'b0, 16'h2040, 1'b0, 0, 1'b0);
        @(negedge clk); check_quiet("t2 gap2");
        expect_fill(1'b1, 16'h3450, 1'b1, 0, 1'b0);
        @(negedge clk); check_quiet("t2 gap3");
        expect_fill(1'b0, 16'h2040, 1'b1, 0, 1'b0);
        @(negedge clk); check_quiet("t2 after");

        // Store raised mid-fill waits, then wins over a still-pending I miss.
        i_miss = 1'b1; i_miss_addr = 16'h400A;
        expect_fill(1'b0, 16'h4000, 1'b0, 3, 1'b0);
        @(negedge clk); check_quiet("t3 grant");
        @(negedge clk);
        check("t3 wr en", 32'(mem_en), 32'(1));
        check("t3 wr wr", 32'(mem_wr), 32'(1));
        check("t3 wr addr", 32'(mem_addr), 32'(16'h5552));
        check("t3 wr data", 32'(mem_wdata), 32'(16'hCAFE));
        check("t3 wr ack", 32'(d_wr_ack), 32'(1));
        check("t3 wr busy", 32'(busy), 32'(1));
        d_wr_req = 1'b0;
        @(negedge clk); check_quiet("t3 after wr");
        expect_fill(1'b0, 16'h4000, 1'b1, 0, 1'b0);
        @(negedge clk); check_quiet("t3 after");

        // Reset after three returned words; late returns must be ignored.
        d_miss = 1'b1; d_miss_addr = 16'h6004;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c >= 5) begin
                check($sformatf("t4 we c%0d", c), 32'(d_fill_we), 32'(1));
                check($sformatf("t4 word c%0d", c), 32'(fill_word), 32'(c - 5));
            end
        end
        rst = 1'b1; d_miss = 1'b0;
        #1;
        check_quiet("t4 rst");
        check("t4 rst word", 32'(fill_word), 32'(0));
        check("t4 rst dones", 32'({i_fill_done, d_fill_done}), 32'(0));
        for (int c = 8; c <= 12; c++) begin
            @(negedge clk);
            rst = 1'b0;
            stray_v = 1'b1; stray_d = 16'hD00D;
            #1;
            check($sformatf("t4 late c%0d", c), 32'({i_fill_we, d_fill_we, busy, mem_en}), 32'(0));
        end
        @(negedge clk);
        stray_v = 1'b0;
        d_miss = 1'b1; d_miss_addr = 16'h6A1E;
        expect_fill(1'b1, 16'h6A10, 1'b1, 0, 1'b0);
        @(negedge clk); check_quiet("t4 after");

        // Stray valid while idle.
        stray_v = 1'b1; stray_d = 16'hBEEF;
        #1;
        check_quiet("t5 stray");
        check("t5 pass", 32'(fill_data), 32'(16'hBEEF));
        @(negedge clk);
        stray_v = 1'b0;
        check_quiet("t5 after");

        // Address change and request drop after grant do not disturb the fill.
        d_miss = 1'b1; d_miss_addr = 16'h7A5C;
        expect_fill(1'b1, 16'h7A50, 1'b1, 0, 1'b1);
        @(negedge clk); check_quiet("t6 after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
